// File: rtl/audio_peak_meter_if.sv
// Mic-sample in / LED-bar out bundle between the mic sampler, the peak meter
// and the display mux.
interface audio_peak_meter_if #(
  parameter int SAMPLE_W = 12,
  parameter int LEVELS   = 9
);
  logic                sample_en;
  logic [SAMPLE_W-1:0] mic_in;
  logic                hold_mode;
  logic [LEVELS-1:0]   led;
  logic [3:0]          level;
  logic [3:0]          hold_level;
  logic                level_valid;

  modport master (
    output sample_en, mic_in, hold_mode,
    input  led, level, hold_level, level_valid
  );

  modport slave (
    input  sample_en, mic_in, hold_mode,
    output led, level, hold_level, level_valid
  );
endinterface

// File: rtl/audio_peak_meter.sv
// Windowed peak-volume meter: tracks peak magnitude above the mic baseline over
// WINDOW strobes, quantises it to 0..LEVELS and drives an LED bar with peak-hold.
module audio_peak_meter #(
  parameter int SAMPLE_W     = 12,
  parameter int BASELINE     = 2048,
  parameter int WINDOW       = 4000,
  parameter int LEVELS       = 9,
  parameter int HOLD_WINDOWS = 5
) (
  input  logic              clock,
  input  logic              reset,
  audio_peak_meter_if.slave bus
);

  localparam int CNT_W   = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int HCNT_W  = (HOLD_WINDOWS > 0) ? $clog2(HOLD_WINDOWS + 1) : 1;
  localparam int FULL    = (1 << SAMPLE_W) - BASELINE;

  localparam logic [SAMPLE_W-1:0] BASE_C    = SAMPLE_W'(BASELINE);
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(WINDOW - 1);
  localparam logic [HCNT_W-1:0]   HCNT_INIT = HCNT_W'(HOLD_WINDOWS);

  function automatic int thr(input int k);
    return (k * FULL) / (LEVELS + 1);
  endfunction

  function automatic logic [3:0] quantise(input logic [SAMPLE_W-1:0] p);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 1; k <= LEVELS; k++) begin
      if (int'(p) >= thr(k)) begin
        n = n + 4'd1;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] pk_q, pk_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic [3:0]          level_q, level_d;
  logic [3:0]          hold_level_q, hold_level_d;
  logic [LEVELS-1:0]   led_q, led_d;
  logic                level_valid_q, level_valid_d;

  logic [SAMPLE_W-1:0] mag_s;
  logic [SAMPLE_W-1:0] peak_s;
  logic [3:0]          newlvl_s;

  // Window accumulation, closing-strobe quantisation and peak-hold decay.
  always_comb begin
    cnt_d         = cnt_q;
    pk_d          = pk_q;
    hcnt_d        = hcnt_q;
    level_d       = level_q;
    hold_level_d  = hold_level_q;
    led_d         = led_q;
    level_valid_d = 1'b0;

    // Samples below the baseline clamp to zero rather than wrapping.
    if (bus.mic_in >= BASE_C) begin
      mag_s = bus.mic_in - BASE_C;
    end else begin
      mag_s = '0;
    end

    if (mag_s > pk_q) begin
      peak_s = mag_s;
    end else begin
      peak_s = pk_q;
    end
    newlvl_s = quantise(peak_s);

    if (bus.sample_en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d         = '0;
        pk_d          = '0;
        level_d       = newlvl_s;
        level_valid_d = 1'b1;

        if (newlvl_s >= hold_level_q) begin
          hold_level_d = newlvl_s;
          hcnt_d       = HCNT_INIT;
        end else if (hcnt_q == '0) begin
          if (hold_level_q != 4'd0) begin
            hold_level_d = hold_level_q - 4'd1;
          end else begin
            hold_level_d = 4'd0;
          end
        end else begin
          hcnt_d = hcnt_q - HCNT_W'(1);
        end

        // Bar from the new level, plus the hold dot drawn from the updated hold level.
        for (int i = 0; i < LEVELS; i++) begin
          led_d[i] = (i < int'(newlvl_s)) ||
                     (bus.hold_mode && (int'(hold_level_d) == i + 1));
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        pk_d  = peak_s;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers; reset discards any partial window.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q         <= '0;
      pk_q          <= '0;
      hcnt_q        <= '0;
      level_q       <= 4'd0;
      hold_level_q  <= 4'd0;
      led_q         <= '0;
      level_valid_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      pk_q          <= pk_d;
      hcnt_q        <= hcnt_d;
      level_q       <= level_d;
      hold_level_q  <= hold_level_d;
      led_q         <= led_d;
      level_valid_q <= level_valid_d;
    end
  end

  assign bus.led         = led_q;
  assign bus.level       = level_q;
  assign bus.hold_level  = hold_level_q;
  assign bus.level_valid = level_valid_q;

endmodule

// File: tb/tb_audio_peak_meter.sv
// Scoreboard bench for audio_peak_meter with WINDOW=4, HOLD_WINDOWS=2.
module tb_audio_peak_meter;

  localparam int WIN  = 4;
  localparam int HOLD = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   valid_cnt = 0;
  int   last_valid_cyc = 0;
  int   prev_valid_cyc = 0;

  audio_peak_meter_if #(.SAMPLE_W(12), .LEVELS(9)) bus ();

  audio_peak_meter #(
    .SAMPLE_W(12), .BASELINE(2048), .WINDOW(WIN), .LEVELS(9), .HOLD_WINDOWS(HOLD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  typedef struct {
    int         lvl;
    int         hold;
    logic [8:0] led;
  } exp_t;

  exp_t sb[$];
  int   thr_tab [9] = '{204, 409, 614, 819, 1024, 1228, 1433, 1638, 1843};
  int   m_cnt, m_pk, m_hold, m_hcnt;

  function automatic int quant(input int p);
    int n = 0;
    for (int k = 0; k < 9; k++) if (p >= thr_tab[k]) n++;
    return n;
  endfunction

  // One strobe; the reference model advances on the edge that registers it.
  task automatic strobe(input int v, input int gap);
    int mag, pkn, nl;
    exp_t e;
    logic [11:0] vv;
    vv = v[11:0];
    bus.sample_en = 1'b1;
    bus.mic_in    = vv;
    @(posedge clock);
    mag = (v >= 2048) ? v - 2048 : 0;
    pkn = (mag > m_pk) ? mag : m_pk;
    if (m_cnt == WIN - 1) begin
      nl = quant(pkn);
      if (nl >= m_hold) begin
        m_hold = nl; m_hcnt = HOLD;
      end else if (m_hcnt == 0) begin
        m_hold = (m_hold > 0) ? m_hold - 1 : 0;
      end else begin
        m_hcnt--;
      end
      e.lvl = nl; e.hold = m_hold;
      for (int i = 0; i < 9; i++)
        e.led[i] = (i < nl) || (bus.hold_mode && (m_hold == i + 1));
      sb.push_back(e);
      m_pk = 0; m_cnt = 0;
    end else begin
      m_pk = pkn; m_cnt++;
    end
    #1 bus.sample_en = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
  endtask

  task automatic window4(input int a, input int b, input int c, input int d, input int gap);
    strobe(a, gap); strobe(b, gap); strobe(c, gap); strobe(d, gap);
  endtask

  task automatic settle();
    @(negedge clock); #1;
  endtask

  // Reset is asserted together with a full-scale strobe, which must be ignored.
  task automatic apply_reset();
    bus.sample_en = 1'b1; bus.mic_in = 12'd4095; reset = 1'b1;
    @(posedge clock); #1;
    bus.sample_en = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    m_cnt = 0; m_pk = 0; m_hold = 0; m_hcnt = 0;
    sb.delete();
  endtask

  // Scoreboard: every level_valid pulse pops and compares one expected update.
  always @(negedge clock) begin
    if (bus.level_valid === 1'b1) begin
      exp_t e;
      valid_cnt++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL valid_spurious got level_valid=1 required 0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        n_checks += 3;
        if (bus.level !== 4'(e.lvl)) begin
          n_fail++; $display("FAIL sb_level got %0d required %0d", bus.level, e.lvl);
        end
        if (bus.hold_level !== 4'(e.hold)) begin
          n_fail++; $display("FAIL sb_hold got %0d required %0d", bus.hold_level, e.hold);
        end
        if (bus.led !== e.led) begin
          n_fail++; $display("FAIL sb_led got %b required %b", bus.led, e.led);
        end
      end
    end
  end

  task automatic check_drained(input string name);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending got %0d outstanding updates required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    settle();
    n_checks += 4;
    if (bus.led !== 9'd0)        begin n_fail++; $display("FAIL reset_led got %b required 0", bus.led); end
    if (bus.level !== 4'd0)      begin n_fail++; $display("FAIL reset_level got %0d required 0", bus.level); end
    if (bus.hold_level !== 4'd0) begin n_fail++; $display("FAIL reset_hold got %0d required 0", bus.hold_level); end
    if (bus.level_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b required 0", bus.level_valid); end
  endtask

  task automatic test_silence();
    int v0;
    v0 = valid_cnt;
    window4(2048, 2048, 2048, 2048, 0);
    settle();
    check_drained("silence");
    n_checks += 3;
    if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL silence_pulses got %0d required 1", valid_cnt - v0); end
    if (bus.level !== 4'd0)  begin n_fail++; $display("FAIL silence_level got %0d required 0", bus.level); end
    if (bus.led !== 9'd0)    begin n_fail++; $display("FAIL silence_led got %b required 0", bus.led); end
  endtask

  task automatic test_peak();
    window4(2048, 3000, 2100, 2200, 0);
    settle();
    check_drained("peak");
    n_checks += 2;
    if (bus.level !== 4'd4)        begin n_fail++; $display("FAIL peak_level got %0d required 4", bus.level); end
    if (bus.led !== 9'b000001111)  begin n_fail++; $display("FAIL peak_led got %b required 000001111", bus.led); end
    window4(2048, 2048, 2048, 2048, 0);
    settle();
    check_drained("peak_clear");
    n_checks++;
    if (bus.level !== 4'd0) begin n_fail++; $display("FAIL peak_clear_level got %0d required 0", bus.level); end
  endtask

  task automatic test_closing_sample();
    window4(2048, 2048, 2048, 4095, 0);
    settle();
    check_drained("closing");
    n_checks += 2;
    if (bus.level !== 4'd9)   begin n_fail++; $display("FAIL closing_level got %0d required 9", bus.level); end
    if (bus.led !== 9'h1FF)   begin n_fail++; $display("FAIL closing_led got %h required 1ff", bus.led); end
  endtask

  task automatic test_hold();
    int         hold_exp [5] = '{7, 7, 7, 6, 5};
    logic [8:0] led_exp  [5] = '{9'h07F, 9'h040, 9'h040, 9'h020, 9'h010};
    apply_reset();
    bus.hold_mode = 1'b1;
    for (int w = 0; w < 5; w++) begin
      if (w == 0) window4(2048, 3548, 2048, 1000, 0);
      else        window4(1000, 1000, 1000, 1000, 0);
      settle();
      check_drained("hold");
      n_checks += 2;
      if (bus.hold_level !== 4'(hold_exp[w])) begin
        n_fail++; $display("FAIL hold_level_w%0d got %0d required %0d", w, bus.hold_level, hold_exp[w]);
      end
      if (bus.led !== led_exp[w]) begin
        n_fail++; $display("FAIL hold_led_w%0d got %b required %b", w, bus.led, led_exp[w]);
      end
    end
    bus.hold_mode = 1'b0;
  endtask

  task automatic test_sparse();
    int v0;
    apply_reset();
    window4(2048, 3000, 2100, 2200, 2);
    settle();
    check_drained("sparse");
    v0 = valid_cnt;
    repeat (12) @(posedge clock);
    settle();
    n_checks += 3;
    if (bus.level !== 4'd4)       begin n_fail++; $display("FAIL sparse_level got %0d required 4", bus.level); end
    if (bus.led !== 9'b000001111) begin n_fail++; $display("FAIL sparse_led got %b required 000001111", bus.led); end
    if (valid_cnt != v0)          begin n_fail++; $display("FAIL sparse_idle_pulses got %0d required 0", valid_cnt - v0); end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_cnt;
    window4(2048, 2500, 2048, 2048, 0);
    window4(2048, 2048, 4000, 2048, 0);
    settle();
    check_drained("b2b");
    n_checks += 3;
    if (valid_cnt - v0 != 2) begin n_fail++; $display("FAIL b2b_pulses got %0d required 2", valid_cnt - v0); end
    if (last_valid_cyc - prev_valid_cyc != WIN) begin
      n_fail++; $display("FAIL b2b_spacing got %0d required %0d", last_valid_cyc - prev_valid_cyc, WIN);
    end
    if (bus.level !== 4'd9) begin n_fail++; $display("FAIL b2b_level got %0d required 9", bus.level); end
  endtask

  task automatic test_reset_mid_window();
    int v0;
    strobe(4095, 0); strobe(4095, 0);
    apply_reset();
    settle();
    n_checks += 3;
    if (bus.level !== 4'd0)      begin n_fail++; $display("FAIL midrst_level got %0d required 0", bus.level); end
    if (bus.led !== 9'd0)        begin n_fail++; $display("FAIL midrst_led got %b required 0", bus.led); end
    if (bus.hold_level !== 4'd0) begin n_fail++; $display("FAIL midrst_hold got %0d required 0", bus.hold_level); end
    v0 = valid_cnt;
    window4(2048, 2048, 2048, 2048, 0);
    settle();
    check_drained("midrst");
    n_checks += 2;
    if (bus.level !== 4'd0)  begin n_fail++; $display("FAIL midrst_after_level got %0d required 0", bus.level); end
    if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL midrst_pulses got %0d required 1", valid_cnt - v0); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sample_en = 1'b0;
    bus.mic_in    = 12'd2048;
    bus.hold_mode = 1'b0;
    @(posedge clock); #1;
    test_reset();
    test_silence();
    test_peak();
    test_closing_sample();
    test_hold();
    test_sparse();
    test_back_to_back();
    test_reset_mid_window();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_peak_meter.md
# audio_peak_meter

Parametrised windowed peak-volume meter for the microphone path. Takes a 12-bit (default) offset-binary mic sample qualified by a sample-enable strobe in the system clock domain, tracks the peak magnitude above the mic baseline over a window of N strobes, and quantises it to a level 0..LEVELS. Drives an LED bar with optional decaying peak-hold dot and a level number for the 7-segment display. Successor to the fixed 20 kHz / 4000-sample / 9-LED meter; sits between the mic sampler and the display mux.

## Interface
- SAMPLE_W, 12: mic sample width.
- BASELINE, 2048: mic quiescent code; magnitudes measured above it.
- WINDOW, 4000: sample strobes per measurement window (≥2).
- LEVELS, 9: number of LED bar segments; level range 0..LEVELS (≤15).
- HOLD_WINDOWS, 5: windows a hold peak persists before decaying.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- sample_en  in  1  one-cycle strobe; mic_in valid when high.
- mic_in  in  SAMPLE_W  raw mic sample.
- hold_mode  in  1  0: plain bar; 1: bar plus peak-hold dot.
- led  out  LEVELS  LED bar.
- level  out  4  quantised level of last completed window.
- hold_level  out  4  current peak-hold level.
- level_valid  out  1  one-cycle pulse when led/level/hold_level update.

## Operation
- Magnitude: mag = mic_in − BASELINE if mic_in ≥ BASELINE, else 0; width SAMPLE_W, never wraps.
- FULL = 2^SAMPLE_W − BASELINE. Thresholds T[k] = floor(k·FULL/(LEVELS+1)), k=1..LEVELS, elaboration-time constants. Defaults: 204, 409, 614, 819, 1024, 1228, 1433, 1638, 1843.
- Quantise: q(p) = count of k with p ≥ T[k].
- Window counter cnt, 0..WINDOW−1, advances only on sample_en. Peak register pk.
- On strobe with cnt < WINDOW−1: pk ← max(pk, mag); cnt ← cnt+1.
- On strobe with cnt = WINDOW−1 (closing strobe): newlvl = q(max(pk, mag)) — closing sample included; level ← newlvl; pk ← 0; cnt ← 0; hold update; led update; level_valid ← 1.
- Hold update (closing strobe only): if newlvl ≥ hold_level: hold_level ← newlvl, hcnt ← HOLD_WINDOWS. Else if hcnt = 0: hold_level ← hold_level − 1 (floor 0). Else hcnt ← hcnt − 1.
- led (registered, computed from the values being written): bits [newlvl−1:0] = 1, others 0. If hold_mode = 1 and post-update hold_level > 0, additionally set bit hold_level−1.
- hold_mode sampled only at the closing strobe; changes take effect at next window update.
- No sample_en: all state static.

## Timing
- Reset: led=0, level=0, hold_level=0, level_valid=0, cnt=0, pk=0, hcnt=0. Reset wins over a simultaneous sample_en; partial window discarded; next window starts at first strobe after reset deasserts.
- Outputs change only on the edge that registers the closing strobe; level_valid high exactly that following cycle, low otherwise.
- Back-to-back strobes (every cycle) supported; a window then spans exactly WINDOW cycles; level_valid pulse every WINDOW cycles.
- Latency: closing sample to visible output = 1 clock edge.
- Max level = LEVELS at mag ≥ T[LEVELS]; mic_in at all-ones gives LEVELS.

## Test plan
- WINDOW=4 bench: reset, 4 strobes of mic_in 2048 -> level=0, led=0, level_valid one cycle after 4th strobe.
- Strobes 2048, 3000, 2100, 2200 -> mag peak 952, level=4, led=9'b000001111; next window of 2048s -> level=0, pk cleared.
- Peak only on closing sample (2048,2048,2048,4095) -> level=9, led=9'h1FF (closing sample counted).
- hold_mode=1, HOLD_WINDOWS=2: one window level 7 then silent windows -> hold_level 7,7,7 (2 hold windows), then 6,5…; led shows only bit hold_level−1; mic_in 1000 (below baseline) treated as 0.
- Sparse strobes (sample_en every 3 cycles) -> identical results to back-to-back; no update without strobes.
- Assert reset after 2 strobes of 4095 -> all outputs 0; following 4 strobes of 2048 -> level=0 (partial window lost), reset+strobe same cycle ignored.
